// File: rtl/usb_pkt_serializer.sv
// usb_pkt_serializer: turns one handshake/token/data packet request into a serial bit stream
// (SYNC, PID, payload, optional CRC), LSB first, one bit per accepted downstream beat.
// Build option: define USB_PKT_CRC_EN to append CRC5/CRC16 inline; otherwise the CRC state
// is skipped and the downstream CRC unit relies on crc_cov/eop.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | pkt_ready=1, waiting for a request with pkt_type != 00
// SYNC     | shifting the 8 SYNC bits; sop on bit 0
// PID      | shifting {~pid, pid}
// PAYLOAD  | token addr+endp (11 bits) or 8*len data bits; crc_cov=1
// CRC      | inverted CRC remainder, MSB first (USB_PKT_CRC_EN only)
// EOP_WAIT | eop=1 until sent_pkt
module usb_pkt_serializer #(
    parameter int          MAX_DATA_BYTES = 8,
    parameter logic [7:0]  SYNC_PATTERN   = 8'h80,
    localparam int         LEN_W          = $clog2(MAX_DATA_BYTES + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pkt_valid,
    output logic                        pkt_ready,
    input  logic [1:0]                  pkt_type,
    input  logic [3:0]                  pid,
    input  logic [6:0]                  tok_addr,
    input  logic [3:0]                  tok_endp,
    input  logic [8*MAX_DATA_BYTES-1:0] data,
    input  logic [LEN_W-1:0]            data_len,
    input  logic                        abort,
    input  logic                        bit_ready,
    output logic                        s_out,
    output logic                        s_valid,
    output logic                        sop,
    output logic                        crc_cov,
    output logic                        eop,
    input  logic                        sent_pkt
);

    localparam int CW = LEN_W + 4;
    localparam int PW = (8 * MAX_DATA_BYTES > 11) ? 8 * MAX_DATA_BYTES : 11;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PID,
        PAYLOAD,
        CRC,
        EOP_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       type_q, type_d;
    logic [3:0]       pid_q, pid_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [PW-1:0]    pay_q, pay_d;

    logic             is_tok;
    logic             is_hs;
    logic             beat;
    logic [7:0]       pid_byte;
    logic [CW-1:0]    pay_last;
    logic [CW-1:0]    crc_last;

    assign is_tok   = (type_q == 2'b01);
    assign is_hs    = (type_q == 2'b10);
    assign pid_byte = {~pid_q, pid_q};
    assign beat     = s_valid & bit_ready;
    assign pay_last = is_tok ? CW'(10) : (CW'({len_q, 3'b000}) - CW'(1));
    assign crc_last = is_tok ? CW'(4) : CW'(15);

`ifdef USB_PKT_CRC_EN
    localparam bit CRC_EN = 1'b1;
    logic [15:0] crc_q, crc_d;
    logic        crc_fb;
    logic        crc_bit;

    // CRC5 lives in crc_q[4:0] (init 1F), CRC16 in the full register (init FFFF)
    always_comb begin
        crc_d  = crc_q;
        crc_fb = pay_q[0] ^ (is_tok ? crc_q[4] : crc_q[15]);
        if (state_q == IDLE) begin
            crc_d = 16'hFFFF;
        end else if (state_q == PAYLOAD && beat) begin
            if (is_tok) begin
                crc_d[4:0] = {crc_q[3:0], 1'b0} ^ (crc_fb ? 5'h05 : 5'h00);
            end else begin
                crc_d = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h8005 : 16'h0000);
            end
        end else if (state_q == CRC && beat) begin
            crc_d = {crc_q[14:0], 1'b0};
        end
    end

    assign crc_bit = ~(is_tok ? crc_q[4] : crc_q[15]);

    // CRC remainder register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 16'hFFFF;
        end else begin
            crc_q <= crc_d;
        end
    end
`else
    localparam bit CRC_EN = 1'b0;
    logic crc_bit;
    assign crc_bit = 1'b0;
`endif

    // next-state, field latching and bit counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        pid_d   = pid_q;
        len_d   = len_q;
        pay_d   = pay_q;
        case (state_q)
            IDLE: begin
                if (pkt_valid && pkt_type != 2'b00) begin
                    state_d = SYNC;
                    cnt_d   = '0;
                    type_d  = pkt_type;
                    pid_d   = pid;
                    len_d   = (data_len > LEN_W'(MAX_DATA_BYTES)) ? LEN_W'(MAX_DATA_BYTES)
                                                                   : data_len;
                    pay_d   = '0;
                    if (pkt_type == 2'b01) begin
                        pay_d[10:0] = {tok_endp, tok_addr};
                    end else begin
                        pay_d[8*MAX_DATA_BYTES-1:0] = data;
                    end
                end
            end
            SYNC: begin
                if (beat) begin
                    if (cnt_q == CW'(7)) begin
                        state_d = PID;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            PID: begin
                if (beat) begin
                    if (cnt_q == CW'(7)) begin
                        cnt_d = '0;
                        if (is_hs) begin
                            state_d = EOP_WAIT;
                        end else if (is_tok || len_q != '0) begin
                            state_d = PAYLOAD;
                        end else begin
                            state_d = CRC_EN ? CRC : EOP_WAIT;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            PAYLOAD: begin
                if (beat) begin
                    pay_d = pay_q >> 1;
                    if (cnt_q == pay_last) begin
                        state_d = CRC_EN ? CRC : EOP_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            CRC: begin
                if (beat) begin
                    if (cnt_q == crc_last) begin
                        state_d = EOP_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            EOP_WAIT: begin
                if (sent_pkt) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // abort wins over any beat or sent_pkt
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // serial outputs are decoded from the registered state, so they hold during stalls
    always_comb begin
        s_out = 1'b0;
        case (state_q)
            SYNC:    s_out = SYNC_PATTERN[cnt_q[2:0]];
            PID:     s_out = pid_byte[cnt_q[2:0]];
            PAYLOAD: s_out = pay_q[0];
            CRC:     s_out = crc_bit;
            default: s_out = 1'b0;
        endcase
    end

    assign pkt_ready = (state_q == IDLE);
    assign s_valid   = (state_q == SYNC) || (state_q == PID) ||
                       (state_q == PAYLOAD) || (state_q == CRC);
    assign sop       = (state_q == SYNC) && (cnt_q == '0);
    assign crc_cov   = (state_q == PAYLOAD);
    assign eop       = (state_q == EOP_WAIT);

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            type_q  <= 2'b00;
            pid_q   <= 4'h0;
            len_q   <= '0;
            pay_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
            pid_q   <= pid_d;
            len_q   <= len_d;
            pay_q   <= pay_d;
        end
    end

endmodule

// File: tb/tb_usb_pkt_serializer.sv
// Bench for usb_pkt_serializer: a table of packets is driven one by one, the expected wire
// bits of each are queued when it is driven and popped on every downstream beat.
// Hand-written sequences cover abort, async reset mid-packet and requests while busy.
module tb_usb_pkt_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [1:0]  pkt_type;
    logic [3:0]  pid;
    logic [6:0]  tok_addr;
    logic [3:0]  tok_endp;
    logic [63:0] data;
    logic [3:0]  data_len;
    logic        abort;
    logic        bit_ready;
    logic        s_out;
    logic        s_valid;
    logic        sop;
    logic        crc_cov;
    logic        eop;
    logic        sent_pkt;

    usb_pkt_serializer #(.MAX_DATA_BYTES(8), .SYNC_PATTERN(8'h80)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_type  (pkt_type),
        .pid       (pid),
        .tok_addr  (tok_addr),
        .tok_endp  (tok_endp),
        .data      (data),
        .data_len  (data_len),
        .abort     (abort),
        .bit_ready (bit_ready),
        .s_out     (s_out),
        .s_valid   (s_valid),
        .sop       (sop),
        .crc_cov   (crc_cov),
        .eop       (eop),
        .sent_pkt  (sent_pkt)
    );

    always #5 clk = ~clk;

`ifdef USB_PKT_CRC_EN
    localparam int C5N  = 5;
    localparam int C16N = 16;
`else
    localparam int C5N  = 0;
    localparam int C16N = 0;
`endif

    typedef struct {
        logic [1:0]  ty;
        logic [3:0]  p;
        logic [6:0]  a;
        logic [3:0]  e;
        logic [63:0] d;
        logic [3:0]  l;
        bit          stall;
        int          nbits;
        int          ncov;
    } vec_t;

    typedef struct {
        logic b;
        logic cov;
        logic sop;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[6];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // reference wire sequence for one packet
    task automatic build_exp(input vec_t v);
        logic [7:0]  sp;
        logic [7:0]  pb;
        logic [10:0] tk;
        int          n;
`ifdef USB_PKT_CRC_EN
        logic [4:0]  c5;
        logic [15:0] c16;
        logic        fb;
        c5  = 5'h1F;
        c16 = 16'hFFFF;
`endif
        exp_q.delete();
        sp = 8'h80;
        pb = {~v.p, v.p};
        for (int i = 0; i < 8; i++) exp_q.push_back('{b: sp[i], cov: 1'b0, sop: (i == 0)});
        for (int i = 0; i < 8; i++) exp_q.push_back('{b: pb[i], cov: 1'b0, sop: 1'b0});
        if (v.ty == 2'b01) begin
            tk = {v.e, v.a};
            for (int i = 0; i < 11; i++) begin
                exp_q.push_back('{b: tk[i], cov: 1'b1, sop: 1'b0});
`ifdef USB_PKT_CRC_EN
                fb = tk[i] ^ c5[4];
                c5 = {c5[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
`endif
            end
`ifdef USB_PKT_CRC_EN
            for (int k = 0; k < 5; k++) exp_q.push_back('{b: ~c5[4-k], cov: 1'b0, sop: 1'b0});
`endif
        end else if (v.ty == 2'b11) begin
            n = (v.l > 4'd8) ? 8 : int'(v.l);
            for (int i = 0; i < 8 * n; i++) begin
                exp_q.push_back('{b: v.d[i], cov: 1'b1, sop: 1'b0});
`ifdef USB_PKT_CRC_EN
                fb  = v.d[i] ^ c16[15];
                c16 = {c16[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
`endif
            end
`ifdef USB_PKT_CRC_EN
            for (int k = 0; k < 16; k++) exp_q.push_back('{b: ~c16[15-k], cov: 1'b0, sop: 1'b0});
`endif
        end
    endtask

    // drive one packet, score every beat, finish with eop/sent_pkt (or abort at beat abort_at)
    task automatic run_pkt(input vec_t v, input int abort_at);
        int   beats;
        int   covs;
        bit   br;
        bit   prev_stall;
        bit   done;
        logic held;
        exp_t e;
        build_exp(v);
        @(negedge clk);
        chk("ready_idle", pkt_ready, 1);
        pkt_valid = 1'b1;
        pkt_type  = v.ty;
        pid       = v.p;
        tok_addr  = v.a;
        tok_endp  = v.e;
        data      = v.d;
        data_len  = v.l;
        @(negedge clk);
        pkt_valid = 1'b0;
        chk("sop_first", sop, 1);
        chk("valid_first", s_valid, 1);
        chk("busy", pkt_ready, 0);
        beats = 0;
        covs = 0;
        prev_stall = 1'b0;
        done = 1'b0;
        held = 1'b0;
        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (prev_stall) chk("hold", s_out, held);
            if (eop) begin
                done = 1'b1;
            end else begin
                if (abort_at >= 0 && beats == abort_at) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    chk("abort_valid", s_valid, 0);
                    chk("abort_eop", eop, 0);
                    chk("abort_cov", crc_cov, 0);
                    chk("abort_ready", pkt_ready, 1);
                    exp_q.delete();
                    return;
                end
                br = v.stall ? (cyc % 2 == 0) : 1'b1;
                bit_ready = br;
                prev_stall = !br && s_valid;
                held = s_out;
                if (s_valid && br) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_bit", beats + 1, v.nbits);
                    end else begin
                        e = exp_q.pop_front();
                        chk("bit", s_out, e.b);
                        chk("cov", crc_cov, e.cov);
                        chk("sop", sop, e.sop);
                    end
                    beats++;
                    if (crc_cov) covs++;
                end
            end
        end
        bit_ready = 1'b1;
        chk("eop_timeout", done, 1);
        chk("nbits", beats, v.nbits);
        chk("ncov", covs, v.ncov);
        chk("queue_empty", exp_q.size(), 0);
        chk("eop_valid", s_valid, 0);
        @(negedge clk);
        chk("eop_hold", eop, 1);
        chk("eop_busy", pkt_ready, 0);
        sent_pkt = 1'b1;
        @(negedge clk);
        sent_pkt = 1'b0;
        chk("eop_clear", eop, 0);
        chk("ready_back", pkt_ready, 1);
    endtask

    initial begin
        bit reached;
        vecs[0] = '{ty: 2'b10, p: 4'h2, a: 7'h00, e: 4'h0, d: 64'h0, l: 4'd0,
                    stall: 1'b0, nbits: 16, ncov: 0};
        vecs[1] = '{ty: 2'b01, p: 4'hD, a: 7'h00, e: 4'h0, d: 64'h0, l: 4'd0,
                    stall: 1'b0, nbits: 27 + C5N, ncov: 11};
        vecs[2] = '{ty: 2'b11, p: 4'h3, a: 7'h00, e: 4'h0, d: 64'h0, l: 4'd0,
                    stall: 1'b0, nbits: 16 + C16N, ncov: 0};
        vecs[3] = '{ty: 2'b11, p: 4'hB, a: 7'h00, e: 4'h0, d: 64'h0807060504030201, l: 4'd8,
                    stall: 1'b1, nbits: 80 + C16N, ncov: 64};
        vecs[4] = '{ty: 2'b11, p: 4'hB, a: 7'h00, e: 4'h0, d: 64'hF00D_CAFE_1234_A5C3, l: 4'd12,
                    stall: 1'b0, nbits: 80 + C16N, ncov: 64};
        vecs[5] = '{ty: 2'b01, p: 4'h9, a: 7'h55, e: 4'hA, d: 64'h0, l: 4'd0,
                    stall: 1'b1, nbits: 27 + C5N, ncov: 11};

        rst_n = 1'b0;
        pkt_valid = 1'b0;
        pkt_type = 2'b00;
        pid = 4'h0;
        tok_addr = 7'h0;
        tok_endp = 4'h0;
        data = 64'h0;
        data_len = 4'd0;
        abort = 1'b0;
        bit_ready = 1'b1;
        sent_pkt = 1'b0;
        #12;
        chk("rst_ready", pkt_ready, 1);
        chk("rst_sout", s_out, 0);
        chk("rst_valid", s_valid, 0);
        chk("rst_sop", sop, 0);
        chk("rst_cov", crc_cov, 0);
        chk("rst_eop", eop, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // type 00 and stray sent_pkt/abort in IDLE are ignored
        @(negedge clk);
        pkt_valid = 1'b1;
        pkt_type = 2'b00;
        sent_pkt = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        pkt_valid = 1'b0;
        sent_pkt = 1'b0;
        abort = 1'b0;
        chk("none_ready", pkt_ready, 1);
        chk("none_valid", s_valid, 0);

        foreach (vecs[i]) run_pkt(vecs[i], -1);

        // abort mid data packet, then an intact ACK
        run_pkt(vecs[4], 20);
        run_pkt(vecs[0], -1);

        // async reset in the middle of a token
        @(negedge clk);
        pkt_valid = 1'b1;
        pkt_type = 2'b01;
        pid = 4'h1;
        tok_addr = 7'h12;
        tok_endp = 4'h3;
        @(negedge clk);
        pkt_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_valid", s_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", pkt_ready, 1);
        chk("arst_valid", s_valid, 0);
        chk("arst_cov", crc_cov, 0);
        chk("arst_sout", s_out, 0);
        chk("arst_eop", eop, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", s_valid, 0);

        // request while in EOP_WAIT must not be taken
        pkt_valid = 1'b1;
        pkt_type = 2'b10;
        pid = 4'h2;
        @(negedge clk);
        pkt_valid = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 100 && !reached; c++) begin
            @(negedge clk);
            if (eop) reached = 1'b1;
        end
        chk("ack_eop_reached", reached, 1);
        pkt_valid = 1'b1;
        pkt_type = 2'b01;
        @(negedge clk);
        chk("busy_eop_ready", pkt_ready, 0);
        @(negedge clk);
        chk("busy_eop_valid", s_valid, 0);
        chk("busy_eop_hold", eop, 1);
        pkt_valid = 1'b0;
        sent_pkt = 1'b1;
        @(negedge clk);
        sent_pkt = 1'b0;
        chk("busy_ready_back", pkt_ready, 1);
        @(negedge clk);
        chk("busy_not_taken", s_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
